onehot_decoder_pipe: RTL and testbench
======================================

Name: onehot_decoder_pipe

Overview:
- Two-stage pipelined binary-index to one-hot decoder; the inverse of the team's 4-to-2 priority encoder.
- Turns a registered index (e.g. an arbiter winner) back into a one-hot select/grant vector.
- valid/ready on both sides, full throughput, backpressure supported.
- Out-of-range indices are flagged, not silently decoded.

Parameters:
- N_OUT, 4, number of one-hot output lines (2..64).
- IDX_W, $clog2(N_OUT), index width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  index present on in_idx
- in_ready  output  1  block accepts in_idx this cycle
- in_idx  input  IDX_W  binary index to decode
- out_valid  output  1  out_onehot/out_err valid
- out_ready  input  1  downstream accepts output
- out_onehot  output  N_OUT  decoded one-hot vector
- out_err  output  1  index was >= N_OUT (out_onehot all-zero)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all stage registers clear, out_valid=0, out_onehot=0, out_err=0. in_ready=1 immediately on reset.
- Stage 1 (S1): registers in_idx and valid bit s1_v on an input handshake (in_valid && in_ready).
- Stage 2 (S2): registers decoded vector, err bit and s2_v.
  - Decode: bit k set iff idx==k, for k<N_OUT.
  - idx>=N_OUT: vector=0, err=1. This can only occur when N_OUT is not a power of two.
- Advance rules:
  - s2_take = !s2_v || out_ready.
  - s1_adv = s1_v && s2_take.
  - in_ready = !s1_v || s1_adv. This is a combinational path from out_ready; accepted by design.
- Latency: 2 cycles from input handshake to out_valid when the pipe is empty.
- Throughput: 1 per cycle while out_ready=1.
- Outputs are driven straight from S2 registers.
- Backpressure (out_ready=0 with S2 full):
  - S2 holds its content stable.
  - S1 fills, then in_ready drops.
  - No index is lost or duplicated.
- Simultaneous load and drain:
  - S1 may load a new index in the same cycle S1 moves to S2.
  - S2 may load in the same cycle its content is consumed.
- Idle S2 (s2_v=0): out_onehot/out_err behaviour is set by the optional feature below.
- Reset mid-operation: both stages are flushed asynchronously; in-flight indices are discarded, never emitted.
- Invariants:
  - out_valid && !out_err implies out_onehot has exactly one bit set.
  - out_err implies out_onehot==0.

Optional Feature:
- Macro: ONEHOT_DEC_HOLD_EN.
- Defined: when S2 drains with no replacement, out_onehot/out_err keep the last emitted value (sticky select for downstream muxes). out_valid still drops.
- Undefined (default): when s2_v=0, out_onehot and out_err are forced to 0.

Decomposition:
- Shared package onehot_dec_pkg holds:
  - the function idx_to_onehot(idx, n), which returns the vector and the err bit;
  - the constant ONEHOT_MAX_N=64.
- The priority encoder and any arbiter reuse the same package.
- One natural sub-module: pipe_stage_reg, a generic valid/ready register slice with width parameter.
  - Instantiated twice: index stage, then decoded-vector stage.
  - The decode logic sits between the two instances.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_onehot=0, in_ready=1. Release, drive idx=2 -> out_onehot=4'b0100 exactly 2 cycles after handshake.
- Streaming: idx sequence 0,1,2,3 back-to-back with out_ready=1 -> outputs 0001,0010,0100,1000 on 4 consecutive cycles, in_ready stays 1.
- Backpressure: send 3,1,0 with out_ready=0 -> out_onehot=1000 held stable and in_ready drops after S1 fills. Raise out_ready -> 1000,0010,0001 in order, none lost.
- Out-of-range, N_OUT=5: idx=6 -> out_valid=1, out_err=1, out_onehot=5'b00000. Next idx=4 -> 5'b10000, out_err=0.
- Async reset mid-flight: assert rst_n=0 between clk edges with both stages full -> out_valid=0 before the next edge. After release, no stale output appears.
- Feature check: idx=1 then idle.
  - Without ONEHOT_DEC_HOLD_EN: out_onehot returns to 0000 once drained.
  - With it: stays 0010 while out_valid=0.

Source files
------------

// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared index/one-hot helpers for the decoder, priority encoder and arbiters
//   ONEHOT_MAX_N  : widest one-hot vector any user of this package may build
//   ONEHOT_IDX_W  : index width that covers ONEHOT_MAX_N lines
//   onehot_res_t  : decode result, full-width vector plus out-of-range flag
//   idx_to_onehot : bit k of vec set iff idx==k and k<n; err set when idx>=n
package onehot_dec_pkg;
  localparam int ONEHOT_MAX_N = 64;
  localparam int ONEHOT_IDX_W = $clog2(ONEHOT_MAX_N);
  typedef struct packed {
    logic                    err;
    logic [ONEHOT_MAX_N-1:0] vec;
  } onehot_res_t;
  function automatic onehot_res_t idx_to_onehot(input logic [ONEHOT_IDX_W-1:0] idx, input int n);
    onehot_res_t r;
    r = '0;
    if (int'(idx) < n) r.vec[idx] = 1'b1;
    else r.err = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/onehot_decoder_pipe_stage.sv
// pipe_stage_reg: generic valid/ready register slice, full throughput, async active-low reset
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake, in_data captured on in_valid && in_ready
//   out_valid/out_ready  : downstream handshake, out_data driven straight from the register
//   W                    : payload width
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;
  // The slice may refill in the same cycle its content is consumed; data is
  // left untouched on drain so a holding consumer can keep showing it.
  always_comb begin
    in_ready = !v_q || out_ready;
    v_d      = in_ready ? in_valid : v_q;
    data_d   = (in_valid && in_ready) ? in_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end
  assign out_valid = v_q;
  assign out_data  = data_q;
endmodule

// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: two-stage pipelined binary-index to one-hot decoder with valid/ready
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : index handshake (in_ready is combinational from out_ready)
//   in_idx [IDX_W]        : binary index to decode
//   out_valid/out_ready   : result handshake
//   out_onehot [N_OUT]    : decoded one-hot vector, all-zero when out_err
//   out_err               : index was >= N_OUT
//   N_OUT                 : number of output lines, 2..64; IDX_W is derived
// Build option ONEHOT_DEC_HOLD_EN: when defined, out_onehot/out_err keep the last
// emitted value while the output stage is empty; otherwise they read zero.
module onehot_decoder_pipe
  import onehot_dec_pkg::*;
#(
  parameter  int N_OUT = 4,
  localparam int IDX_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_onehot,
  output logic             out_err
);
  if (N_OUT < 2 || N_OUT > ONEHOT_MAX_N) begin : g_bad_n
    $error("onehot_decoder_pipe: N_OUT out of range 2..%0d", ONEHOT_MAX_N);
  end
  logic             s1_v, s2_v, s2_take;
  logic [IDX_W-1:0] s1_idx;
  onehot_res_t      dec;
  logic [N_OUT:0]   s2_in, s2_q;
  pipe_stage_reg #(.W(IDX_W)) u_idx_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_idx),
    .in_ready  (in_ready),
    .out_valid (s1_v),
    .out_data  (s1_idx),
    .out_ready (s2_take)
  );
  assign dec = idx_to_onehot(ONEHOT_IDX_W'(s1_idx), N_OUT);
  // Bits of dec.vec at or above N_OUT are always zero; folding them into err
  // keeps every result bit live without changing behaviour.
  assign s2_in = {dec.err | (|(dec.vec >> N_OUT)), dec.vec[N_OUT-1:0]};
  pipe_stage_reg #(.W(N_OUT + 1)) u_vec_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_v),
    .in_data   (s2_in),
    .in_ready  (s2_take),
    .out_valid (s2_v),
    .out_data  (s2_q),
    .out_ready (out_ready)
  );
  assign out_valid = s2_v;
`ifdef ONEHOT_DEC_HOLD_EN
  assign out_onehot = s2_q[N_OUT-1:0];
  assign out_err    = s2_q[N_OUT];
`else
  assign out_onehot = s2_v ? s2_q[N_OUT-1:0] : '0;
  assign out_err    = s2_v & s2_q[N_OUT];
`endif
endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb_onehot_decoder_pipe: directed table-driven bench for onehot_decoder_pipe (N_OUT=4 and 5)
module tb_onehot_decoder_pipe;
`ifdef ONEHOT_DEC_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n;
  logic       v4, r4, ir4, ov4, err4;
  logic [1:0] idx4;
  logic [3:0] oh4;
  logic       v5, r5, ir5, ov5, err5;
  logic [2:0] idx5;
  logic [4:0] oh5;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  onehot_decoder_pipe #(.N_OUT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_idx(idx4),
    .out_valid(ov4), .out_ready(r4), .out_onehot(oh4), .out_err(err4)
  );
  onehot_decoder_pipe #(.N_OUT(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(ir5), .in_idx(idx5),
    .out_valid(ov5), .out_ready(r5), .out_onehot(oh5), .out_err(err5)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct packed {
    logic       v;
    logic [1:0] idx;
    logic       rdy;
    logic       exp_ir;
    logic       exp_ov;
    logic [3:0] exp_oh;
    logic [3:0] exp_oh_hold;
  } vec_t;
  vec_t tbl [20];
  initial begin
    // {in_valid, idx, out_ready, in_ready(pre-edge), out_valid, onehot, onehot when holding}
    tbl[0]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0100};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100};
    tbl[3]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100};
    tbl[4]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0001};
    tbl[5]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0010};
    tbl[6]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0100};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b1000};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000};
    tbl[9]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b1000};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000};
    tbl[12] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000};
    tbl[13] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0010};
    tbl[14] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0001};
    tbl[15] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001};
    tbl[16] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001};
    tbl[17] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0010};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010};
    tbl[19] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010};
    rst_n = 1'b0;
    v4 = 1'b1; idx4 = 2'd1; r4 = 1'b1;
    v5 = 1'b1; idx5 = 3'd3; r5 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst out_valid4", 64'(ov4), 64'd0);
    chk("rst onehot4", 64'(oh4), 64'd0);
    chk("rst in_ready4", 64'(ir4), 64'd1);
    chk("rst out_valid5", 64'(ov5), 64'd0);
    chk("rst onehot5", 64'(oh5), 64'd0);
    chk("rst err5", 64'(err5), 64'd0);
    v4 = 1'b0; v5 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v4 = tbl[i].v; idx4 = tbl[i].idx; r4 = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d in_ready", i), 64'(ir4), 64'(tbl[i].exp_ir));
      @(negedge clk);
      chk($sformatf("row%0d out_valid", i), 64'(ov4), 64'(tbl[i].exp_ov));
      chk($sformatf("row%0d onehot", i), 64'(oh4), 64'(HOLD ? tbl[i].exp_oh_hold : tbl[i].exp_oh));
      chk($sformatf("row%0d err", i), 64'(err4), 64'd0);
      if (ov4) chk($sformatf("row%0d onehot count", i), 64'($countones(oh4)), 64'd1);
    end
    v5 = 1'b1; idx5 = 3'd6;
    @(negedge clk);
    idx5 = 3'd4;
    @(negedge clk);
    v5 = 1'b0;
    chk("n5 idx6 valid", 64'(ov5), 64'd1);
    chk("n5 idx6 err", 64'(err5), 64'd1);
    chk("n5 idx6 onehot", 64'(oh5), 64'd0);
    @(negedge clk);
    chk("n5 idx4 valid", 64'(ov5), 64'd1);
    chk("n5 idx4 err", 64'(err5), 64'd0);
    chk("n5 idx4 onehot", 64'(oh5), 64'b10000);
    @(negedge clk);
    chk("n5 drained valid", 64'(ov5), 64'd0);
    v4 = 1'b1; idx4 = 2'd3; r4 = 1'b0;
    @(negedge clk);
    idx4 = 2'd2;
    @(negedge clk);
    v4 = 1'b0;
    chk("arst pre valid", 64'(ov4), 64'd1);
    chk("arst pre in_ready", 64'(ir4), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 64'(ov4), 64'd0);
    chk("arst onehot", 64'(oh4), 64'd0);
    chk("arst in_ready", 64'(ir4), 64'd1);
    r4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post arst valid%0d", i), 64'(ov4), 64'd0);
      chk($sformatf("post arst onehot%0d", i), 64'(oh4), 64'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
